// File: rtl/div_unit_pkg.sv
// Shared types and constants for the multi-cycle divider: FSM state codes,
// reset polarity and ready encodings.
package div_unit_pkg;

  localparam logic RST_ENABLE       = 1'b0;
  localparam logic RESULT_READY     = 1'b1;
  localparam logic RESULT_NOT_READY = 1'b0;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

endpackage

// File: rtl/div_unit_if.sv
// Request/result bundle between the EX stage (master) and the divider (slave).
interface div_unit_if #(
  parameter int DW = 32
);
  logic            signed_div_i;
  logic [DW-1:0]   opdata1_i;
  logic [DW-1:0]   opdata2_i;
  logic            start_i;
  logic            annul_i;
  logic [2*DW-1:0] result_o;
  logic            ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div_unit.sv
// Restoring divider for DIV/DIVU: one quotient bit per cycle, magnitudes are
// divided and the signs of the latched operands are applied at the end.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DW    = 32,
  parameter int CNT_W = 6
) (
  input logic       clk,
  input logic       rst_n,
  div_unit_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DW);

  div_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [2*DW:0]   dvd_q;
  logic [DW-1:0]   dsr_q;
  logic            sgn_q;
  logic            op1_msb_q;
  logic            op2_msb_q;
  logic [2*DW-1:0] result_q;

  logic [DW:0]     trial;
  logic [DW-1:0]   quot_fix;
  logic [DW-1:0]   rem_fix;
  logic            accept;

  function automatic logic [DW-1:0] abs_op(input logic [DW-1:0] v, input logic sgn);
    logic signed [DW-1:0] s;
    s = signed'(v);
    return (sgn && s < 0) ? DW'(-s) : v;
  endfunction

  function automatic logic [DW-1:0] neg_if(input logic [DW-1:0] v, input logic en);
    return en ? (~v + DW'(1)) : v;
  endfunction

  assign accept   = bus.start_i && !bus.annul_i;
  assign trial    = {1'b0, dvd_q[2*DW-1:DW]} - {1'b0, dsr_q};
  assign quot_fix = neg_if(dvd_q[DW-1:0], sgn_q && (op1_msb_q ^ op2_msb_q));
  assign rem_fix  = neg_if(dvd_q[2*DW:DW+1], sgn_q && op1_msb_q);

  always_ff @(posedge clk) begin
    if (rst_n == RST_ENABLE) state_q <= DIV_FREE;
    else                     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DIV_FREE:   if (accept) state_d = (bus.opdata2_i == '0) ? DIV_BYZERO : DIV_ON;
      DIV_BYZERO: state_d = DIV_END;
      DIV_ON: begin
        if (bus.annul_i)            state_d = DIV_FREE;
        else if (cnt_q == CNT_LAST) state_d = DIV_END;
      end
      DIV_END:    if (!bus.start_i || bus.annul_i) state_d = DIV_FREE;
      default:    state_d = DIV_FREE;
    endcase
  end

  always_comb begin
    bus.ready_o  = (state_q == DIV_END) ? RESULT_READY : RESULT_NOT_READY;
    bus.result_o = result_q;
  end

  // Control: iteration counter and the registered result
  always_ff @(posedge clk) begin
    if (rst_n == RST_ENABLE) begin
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      unique case (state_q)
        DIV_FREE: begin
          cnt_q    <= '0;
          result_q <= '0;
        end
        DIV_BYZERO: result_q <= '0;
        DIV_ON: begin
          if (bus.annul_i)            cnt_q <= '0;
          else if (cnt_q != CNT_LAST) cnt_q <= cnt_q + CNT_W'(1);
          else                        result_q <= {rem_fix, quot_fix};
        end
        DIV_END:  if (!bus.start_i || bus.annul_i) result_q <= '0;
        default:  result_q <= '0;
      endcase
    end
  end

  // Datapath: operand capture at start, then one trial subtraction per cycle
  always_ff @(posedge clk) begin
    if (state_q == DIV_FREE && accept) begin
      sgn_q     <= bus.signed_div_i;
      op1_msb_q <= bus.opdata1_i[DW-1];
      op2_msb_q <= bus.opdata2_i[DW-1];
      dsr_q     <= abs_op(bus.opdata2_i, bus.signed_div_i);
      dvd_q     <= {{DW{1'b0}}, abs_op(bus.opdata1_i, bus.signed_div_i), 1'b0};
    end else if (state_q == DIV_ON && !bus.annul_i && cnt_q != CNT_LAST) begin
      if (trial[DW]) dvd_q <= {dvd_q[2*DW-1:0], 1'b0};
      else           dvd_q <= {trial[DW-1:0], dvd_q[DW-1:0], 1'b1};
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, signed/unsigned results, divide by
// zero, annul, overflow wrap, mid-divide reset and operand stability.
module tb_div_unit;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  div_unit_if #(.DW(32)) bus ();

  div_unit #(.DW(32), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
  endtask

  // Issues a divide and returns ready after edge E+32 and ready/result after E+33.
  task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        output logic rdy_before, output logic rdy_at, output logic [63:0] res);
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
    bus.annul_i      = 1'b0;
    step();
    repeat (32) step();
    rdy_before = bus.ready_o;
    step();
    rdy_at = bus.ready_o;
    res    = bus.result_o;
  endtask

  task automatic release_start();
    bus.start_i = 1'b0;
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if (bus.ready_o !== 1'b0) begin
      errors++; $display("FAIL reset_ready got=%b exp=0", bus.ready_o);
    end
    checks++;
    if (bus.result_o !== 64'd0) begin
      errors++; $display("FAIL reset_result got=%h exp=0", bus.result_o);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_unsigned();
    logic rb, ra;
    logic [63:0] r;
    do_div(1'b0, 32'd100, 32'd7, rb, ra, r);
    checks++;
    if (rb !== 1'b0) begin errors++; $display("FAIL udiv_early_ready got=%b exp=0", rb); end
    checks++;
    if (ra !== 1'b1) begin errors++; $display("FAIL udiv_ready got=%b exp=1", ra); end
    checks++;
    if (r !== {32'd2, 32'd14}) begin errors++; $display("FAIL udiv_result got=%h exp=%h", r, {32'd2, 32'd14}); end
    step();
    checks++;
    if (bus.ready_o !== 1'b1 || bus.result_o !== {32'd2, 32'd14}) begin
      errors++; $display("FAIL udiv_hold got=%b/%h exp=1/%h", bus.ready_o, bus.result_o, {32'd2, 32'd14});
    end
    release_start();
    checks++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
      errors++; $display("FAIL udiv_drop got=%b/%h exp=0/0", bus.ready_o, bus.result_o);
    end
    do_div(1'b0, 32'hFFFF_FFFF, 32'h10, rb, ra, r);
    checks++;
    if (ra !== 1'b1 || r !== {32'h0000_000F, 32'h0FFF_FFFF}) begin
      errors++; $display("FAIL udiv_large got=%b/%h exp=1/%h", ra, r, {32'h0000_000F, 32'h0FFF_FFFF});
    end
    release_start();
  endtask

  task automatic test_signed();
    logic rb, ra;
    logic [63:0] r;
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, rb, ra, r);
    checks++;
    if (ra !== 1'b1 || r !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
      errors++; $display("FAIL sdiv_neg_dividend got=%b/%h exp=1/%h", ra, r, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    end
    release_start();
    do_div(1'b1, 32'd7, 32'hFFFF_FFFE, rb, ra, r);
    checks++;
    if (ra !== 1'b1 || r !== {32'd1, 32'hFFFF_FFFD}) begin
      errors++; $display("FAIL sdiv_neg_divisor got=%b/%h exp=1/%h", ra, r, {32'd1, 32'hFFFF_FFFD});
    end
    release_start();
  endtask

  task automatic test_byzero();
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'h1234;
    bus.opdata2_i    = 32'd0;
    bus.start_i      = 1'b1;
    bus.annul_i      = 1'b0;
    step();
    checks++;
    if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL byzero_early got=%b exp=0", bus.ready_o); end
    step();
    checks++;
    if (bus.ready_o !== 1'b1 || bus.result_o !== 64'd0) begin
      errors++; $display("FAIL byzero_result got=%b/%h exp=1/0", bus.ready_o, bus.result_o);
    end
    release_start();
  endtask

  task automatic test_annul();
    logic rb, ra;
    logic [63:0] r;
    int bad;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd1000;
    bus.opdata2_i    = 32'd3;
    bus.start_i      = 1'b1;
    bus.annul_i      = 1'b0;
    step();
    repeat (10) step();
    bus.annul_i = 1'b1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.ready_o !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL annul_no_ready got=%0d ready cycles exp=0", bad); end
    bus.annul_i = 1'b0;
    release_start();
    do_div(1'b0, 32'd9, 32'd3, rb, ra, r);
    checks++;
    if (rb !== 1'b0 || ra !== 1'b1 || r !== {32'd0, 32'd3}) begin
      errors++; $display("FAIL annul_restart got=%b%b/%h exp=01/%h", rb, ra, r, {32'd0, 32'd3});
    end
    release_start();
  endtask

  task automatic test_overflow();
    logic rb, ra;
    logic [63:0] r;
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, rb, ra, r);
    checks++;
    if (ra !== 1'b1 || r !== {32'd0, 32'h8000_0000}) begin
      errors++; $display("FAIL sdiv_overflow got=%b/%h exp=1/%h", ra, r, {32'd0, 32'h8000_0000});
    end
    release_start();
  endtask

  task automatic test_reset_mid();
    int bad;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd1000;
    bus.opdata2_i    = 32'd7;
    bus.start_i      = 1'b1;
    bus.annul_i      = 1'b0;
    step();
    repeat (20) step();
    rst_n = 1'b0;
    step();
    checks++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
      errors++; $display("FAIL reset_mid got=%b/%h exp=0/0", bus.ready_o, bus.result_o);
    end
    rst_n = 1'b1;
    bus.start_i = 1'b0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL reset_mid_idle got=%0d busy cycles exp=0", bad); end
  endtask

  task automatic test_operand_change();
    bus.signed_div_i = 1'b1;
    bus.opdata1_i    = 32'hFFFF_FF9C;
    bus.opdata2_i    = 32'd7;
    bus.start_i      = 1'b1;
    bus.annul_i      = 1'b0;
    step();
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd5;
    bus.opdata2_i    = 32'd0;
    repeat (33) step();
    checks++;
    if (bus.ready_o !== 1'b1 || bus.result_o !== {32'hFFFF_FFFE, 32'hFFFF_FFF2}) begin
      errors++; $display("FAIL operand_change got=%b/%h exp=1/%h", bus.ready_o, bus.result_o,
                         {32'hFFFF_FFFE, 32'hFFFF_FFF2});
    end
    release_start();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    idle_inputs();
    test_reset();
    test_unsigned();
    test_signed();
    test_byzero();
    test_annul();
    test_overflow();
    test_reset_mid();
    test_operand_change();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
